// File: rtl/matrix_input_parser.sv
// Parses a UART ASCII stream of "rows cols e0 e1 ..." decimal tokens and writes each element to matrix storage.
// Elements are written one cycle after their terminating separator. done/err pulse once, then the block waits for start to drop.
module matrix_input_parser #(
   parameter int MAX_DIM = 5,
   parameter int DATA_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [2:0]        matrix_row,
   output logic [2:0]        matrix_col,
   output logic              wr_en,
   output logic [4:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   typedef enum logic [2:0] {
      IDLE, GET_ROW, GET_COL, GET_ELEM, FINISH, FAIL, WAIT_RELEASE
   } state_t;

   localparam logic [9:0] VAL_MAX = 10'((1 << DATA_W) - 1);
   localparam logic [9:0] DIM_MAX = 10'(MAX_DIM);

   state_t     state;
   logic [9:0] acc;
   logic [1:0] dig_cnt;
   logic [4:0] elem_cnt;

   logic       is_digit;
   logic       is_sep;
   logic       tok_ovf;
   logic       dim_ok;
   logic [5:0] total;
   logic [5:0] elem_next;

   always_comb begin
      is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      is_sep    = (rx_data == 8'h20) || (rx_data == 8'h09) ||
                  (rx_data == 8'h0D) || (rx_data == 8'h0A);
      tok_ovf   = acc > VAL_MAX;
      dim_ok    = (acc >= 10'd1) && (acc <= DIM_MAX);
      total     = {3'd0, matrix_row} * {3'd0, matrix_col};
      elem_next = {1'b0, elem_cnt} + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
         matrix_row <= 3'd0;
         matrix_col <= 3'd0;
         wr_en      <= 1'b0;
         wr_addr    <= 5'd0;
         wr_data    <= '0;
         acc        <= 10'd0;
         dig_cnt    <= 2'd0;
         elem_cnt   <= 5'd0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= GET_ROW;
                  busy     <= 1'b1;
                  err_code <= 2'd0;
                  acc      <= 10'd0;
                  dig_cnt  <= 2'd0;
                  elem_cnt <= 5'd0;
               end
            end
            GET_ROW, GET_COL, GET_ELEM: begin
               if (rx_valid) begin
                  if (is_digit) begin
                     // A fourth digit can never be legal, so abort before acc can wrap.
                     if (dig_cnt == 2'd3) begin
                        state    <= FAIL;
                        err_code <= 2'd2;
                     end else begin
                        acc     <= acc * 10'd10 + {6'd0, rx_data[3:0]};
                        dig_cnt <= dig_cnt + 2'd1;
                     end
                  end else if (is_sep) begin
                     if (dig_cnt != 2'd0) begin
                        acc     <= 10'd0;
                        dig_cnt <= 2'd0;
                        if (tok_ovf) begin
                           state    <= FAIL;
                           err_code <= 2'd2;
                        end else if (state == GET_ROW || state == GET_COL) begin
                           if (!dim_ok) begin
                              state    <= FAIL;
                              err_code <= 2'd3;
                           end else if (state == GET_ROW) begin
                              matrix_row <= acc[2:0];
                              state      <= GET_COL;
                           end else begin
                              matrix_col <= acc[2:0];
                              state      <= GET_ELEM;
                           end
                        end else begin
                           wr_en    <= 1'b1;
                           wr_addr  <= elem_cnt;
                           wr_data  <= acc[DATA_W-1:0];
                           elem_cnt <= elem_next[4:0];
                           if (elem_next == total) state <= FINISH;
                        end
                     end
                  end else begin
                     state    <= FAIL;
                     err_code <= 2'd1;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= WAIT_RELEASE;
            end
            FAIL: begin
               err   <= 1'b1;
               busy  <= 1'b0;
               state <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (!start) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser: sends ASCII streams and checks writes, pulses and error codes.
module tb_matrix_input_parser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       busy, done, err, wr_en;
   logic [1:0] err_code;
   logic [2:0] matrix_row, matrix_col;
   logic [4:0] wr_addr;
   logic [8:0] wr_data;

   matrix_input_parser #(.MAX_DIM(5), .DATA_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .matrix_row(matrix_row), .matrix_col(matrix_col),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int wr_n = 0, done_n = 0, err_n = 0, done_cyc = 0;
   int addr_log [64];
   int data_log [64];
   int wcyc_log [64];
   int checks = 0, passes = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en && wr_n < 64) begin
         addr_log[wr_n] = int'(wr_addr);
         data_log[wr_n] = int'(wr_data);
         wcyc_log[wr_n] = cyc;
         wr_n++;
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
      if (err) err_n++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = s[i];
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(4);
   endtask

   int base_w, base_d, base_e;

   initial begin
      // Reset state
      tick(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_row", int'(matrix_row), 0);
      rst_n = 1'b1;
      tick(2);

      // 2x3 matrix with newlines
      base_w = wr_n; base_d = done_n; base_e = err_n;
      do_start();
      chk("t1_busy", int'(busy), 1);
      send_str("2 3\n1 2 3\n4 5 6\n");
      chk("t1_nwr", wr_n - base_w, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_addr%0d", i), addr_log[base_w + i], i);
         chk($sformatf("t1_data%0d", i), data_log[base_w + i], i + 1);
      end
      chk("t1_row", int'(matrix_row), 2);
      chk("t1_col", int'(matrix_col), 3);
      chk("t1_done_n", done_n - base_d, 1);
      chk("t1_done_cyc", done_cyc, wcyc_log[base_w + 5] + 1);
      chk("t1_err_n", err_n - base_e, 0);
      chk("t1_busy_end", int'(busy), 0);

      // Largest legal value, then one past it
      base_w = wr_n; base_d = done_n;
      do_start();
      send_str("1 1 511 ");
      chk("t2_nwr", wr_n - base_w, 1);
      chk("t2_addr", addr_log[base_w], 0);
      chk("t2_data", data_log[base_w], 511);
      chk("t2_done_n", done_n - base_d, 1);
      base_w = wr_n; base_e = err_n;
      do_start();
      send_str("1 1 512 ");
      chk("t2b_nwr", wr_n - base_w, 0);
      chk("t2b_err_n", err_n - base_e, 1);
      chk("t2b_code", int'(err_code), 2);

      // Illegal dimensions
      base_e = err_n;
      do_start();
      send_str("6 2 ");
      chk("t3_err_n", err_n - base_e, 1);
      chk("t3_code", int'(err_code), 3);
      chk("t3_row", int'(matrix_row), 1);
      do_start();
      chk("t3_code_clr", int'(err_code), 0);
      send_str("0 2 ");
      chk("t3b_code", int'(err_code), 3);
      chk("t3b_err_n", err_n - base_e, 2);

      // Illegal character after one element
      base_w = wr_n; base_e = err_n; base_d = done_n;
      do_start();
      send_str("2 2 1 x");
      chk("t4_nwr", wr_n - base_w, 1);
      chk("t4_addr", addr_log[base_w], 0);
      chk("t4_data", data_log[base_w], 1);
      chk("t4_code", int'(err_code), 1);
      chk("t4_err_n", err_n - base_e, 1);
      chk("t4_done_n", done_n - base_d, 0);

      // Back-to-back separators with start held high
      base_w = wr_n; base_d = done_n;
      @(negedge clk); start = 1'b1;
      send_str("  1\r\n\t2   7 8 ");
      chk("t5_nwr", wr_n - base_w, 2);
      chk("t5_addr0", addr_log[base_w], 0);
      chk("t5_data0", data_log[base_w], 7);
      chk("t5_addr1", addr_log[base_w + 1], 1);
      chk("t5_data1", data_log[base_w + 1], 8);
      chk("t5_done_n", done_n - base_d, 1);
      chk("t5_col", int'(matrix_col), 2);
      base_w = wr_n;
      send_str("1 1 5 ");
      chk("t5_held_nwr", wr_n - base_w, 0);
      chk("t5_held_busy", int'(busy), 0);
      @(negedge clk); start = 1'b0;
      tick(2);
      do_start();
      send_str("1 1 5 ");
      chk("t5_rearm_nwr", wr_n - base_w, 1);
      chk("t5_rearm_data", data_log[base_w], 5);

      // Reset in the middle of a parse
      base_w = wr_n;
      do_start();
      send_str("2 2 1 2 3 ");
      chk("t6_nwr", wr_n - base_w, 3);
      chk("t6_busy", int'(busy), 1);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6_busy_rst", int'(busy), 0);
      chk("t6_addr_rst", int'(wr_addr), 0);
      chk("t6_data_rst", int'(wr_data), 0);
      chk("t6_row_rst", int'(matrix_row), 0);
      chk("t6_col_rst", int'(matrix_col), 0);
      chk("t6_wr_en_rst", int'(wr_en), 0);
      @(negedge clk); rst_n = 1'b1;
      base_w = wr_n;
      send_str("1 1 5 ");
      chk("t6_idle_nwr", wr_n - base_w, 0);
      chk("t6_idle_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed %0d/%0d", passes, checks);
      $fatal(1, "timeout");
   end

endmodule
